// File: rtl/ntt_intt_seq_if.sv
// Host-side bundle for ntt_intt_seq: command handshake, coefficient input stream
// and result output stream. The sequencer uses the slave modport.
interface ntt_intt_seq_if;
  logic        cmd_valid;
  logic        cmd_inv;
  logic        cmd_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output cmd_valid, cmd_inv, in_data, in_valid, out_ready,
    input  cmd_ready, in_ready, out_data, out_valid
  );

  modport slave (
    input  cmd_valid, cmd_inv, in_data, in_valid, out_ready,
    output cmd_ready, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ntt_intt_seq.sv
// Sequencer between a host stream and an NTT/INTT core: load, start, wait, drain.
// Defining NTT_SEQ_PERF_CNT_EN adds a perf_cycles output counting START..WAIT cycles.
module ntt_intt_seq #(
  parameter int NWORDS = 128,
  parameter int NCNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  ntt_intt_seq_if.slave host,
  output logic          load_a_f,
  output logic          load_a_i,
  output logic          read_a,
  output logic          start_fntt,
  output logic          start_intt,
  output logic [31:0]   din,
  output logic          din_en,
  output logic          read_en,
  input  logic [31:0]   core_dout,
  input  logic          gnt_valid,
  input  logic          core_done,
  output logic          busy,
  output logic          err
`ifdef NTT_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, LDCMD, LOAD, START, WAIT, RDCMD, DRAIN} state_t;

  localparam logic [NCNT_W-1:0] LAST = NCNT_W'(NWORDS - 1);
  localparam logic [NCNT_W-1:0] FULL = NCNT_W'(NWORDS);

  state_t            state;
  state_t            state_nxt;
  logic [NCNT_W-1:0] wcnt;
  logic              inv_q;
  logic              outstanding;
  logic              out_valid_q;
  logic [31:0]       out_data_q;
  logic              err_q;
  logic              cmd_ready_c;
  logic              in_ready_c;
  logic              cmd_fire;
  logic              in_fire;
  logic              capture;
  logic              pop;

  assign cmd_fire = cmd_ready_c && host.cmd_valid;
  assign in_fire  = in_ready_c && host.in_valid;
  assign capture  = gnt_valid && outstanding;
  assign pop      = out_valid_q && host.out_ready;

  assign host.cmd_ready = cmd_ready_c;
  assign host.in_ready  = in_ready_c;
  assign host.out_data  = out_data_q;
  assign host.out_valid = out_valid_q;
  assign din_en         = in_fire;
  assign din            = in_ready_c ? host.in_data : 32'h0;
  assign busy           = (state != IDLE);
  assign err            = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Strobes decode straight from the state, so each lasts exactly one cycle.
  // A new read is requested only when the output register can take the grant.
  always_comb begin
    state_nxt   = state;
    cmd_ready_c = 1'b0;
    in_ready_c  = 1'b0;
    load_a_f    = 1'b0;
    load_a_i    = 1'b0;
    start_fntt  = 1'b0;
    start_intt  = 1'b0;
    read_a      = 1'b0;
    read_en     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (host.cmd_valid) state_nxt = LDCMD;
      end
      LDCMD: begin
        load_a_f  = !inv_q;
        load_a_i  = inv_q;
        state_nxt = LOAD;
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (host.in_valid && (wcnt == LAST)) state_nxt = START;
      end
      START: begin
        start_fntt = !inv_q;
        start_intt = inv_q;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) state_nxt = RDCMD;
      end
      RDCMD: begin
        read_a    = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        read_en = !outstanding && (!out_valid_q || host.out_ready) && (wcnt < FULL);
        if (pop && !outstanding && (wcnt == FULL)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wcnt counts accepted words while loading and captured words while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt        <= '0;
      inv_q       <= 1'b0;
      outstanding <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      if (cmd_fire) inv_q <= host.cmd_inv;

      if (cmd_fire || (state == RDCMD)) wcnt <= '0;
      else if (in_fire || capture)      wcnt <= wcnt + 1'b1;

      if (capture)      outstanding <= 1'b0;
      else if (read_en) outstanding <= 1'b1;

      if (capture) begin
        out_data_q  <= core_dout;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end

      if ((gnt_valid && !outstanding) || (core_done && (state != WAIT))) err_q <= 1'b1;
    end
  end

`ifdef NTT_SEQ_PERF_CNT_EN
  // The cycle in which core_done is seen is not counted, so the value is the
  // number of cycles from the start pulse until the core reports completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             perf_cycles <= 32'h0;
    else if (cmd_fire)                                   perf_cycles <= 32'h0;
    else if ((state == START) || ((state == WAIT) && !core_done)) perf_cycles <= perf_cycles + 32'h1;
  end
`endif

endmodule
